// File: rtl/cmd_framer.sv
// Round-robin packet framer: serialises messages from N_SRC show-ahead FIFOs
// into prefix / source / length / payload / check byte frames on a valid/ready stream.
module cmd_framer #(
  parameter int         N_SRC    = 8,
  parameter logic [7:0] PREFIX   = 8'hAA,
  parameter int         CHK_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   have_msg_bus,
  input  logic [8*N_SRC-1:0] len_bus,
  input  logic [8*N_SRC-1:0] data_bus,
  output logic [N_SRC-1:0]   rdreq_bus,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               frame_done
);

  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFIX,
    S_SOURCE,
    S_LEN,
    S_DATA,
    S_CHK
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [SW-1:0] r_src;
  logic [SW-1:0] r_last;
  logic [SW-1:0] w_grant;
  logic [SW-1:0] w_scan;
  logic [7:0]    r_len;
  logic [7:0]    r_cnt;
  logic [7:0]    r_chk;
  logic [7:0]    w_chkNext;
  logic          r_done;
  logic          w_found;
  logic          w_hs;
  logic [7:0]    w_lenArr  [N_SRC];
  logic [7:0]    w_dataArr [N_SRC];

  // One CRC-8 (poly 0x07) step over a whole byte, MSB first.
  function automatic logic [7:0] crc8Step(input logic [7:0] crc, input logic [7:0] din);
    logic [7:0] x;
    x = crc ^ din;
    for (int b = 0; b < 8; b++) begin
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07) : {x[6:0], 1'b0};
    end
    return x;
  endfunction

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign w_lenArr[g]  = len_bus[8*g +: 8];
    assign w_dataArr[g] = data_bus[8*g +: 8];
  end

  // Circular scan starting just after the last grant, so a served source drops to the back.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_scan  = r_last;
    for (int k = 0; k < N_SRC; k++) begin
      w_scan = (w_scan == SW'(N_SRC - 1)) ? '0 : w_scan + 1'b1;
      if (!w_found && have_msg_bus[w_scan]) begin
        w_found = 1'b1;
        w_grant = w_scan;
      end
    end
  end

  always_comb begin
    tx_data = '0;
    case (r_state)
      S_PREFIX: tx_data = PREFIX;
      S_SOURCE: tx_data = 8'(r_src);
      S_LEN:    tx_data = r_len;
      S_DATA:   tx_data = w_dataArr[r_src];
      S_CHK:    tx_data = r_chk;
      default:  tx_data = '0;
    endcase
    tx_valid   = (r_state != S_IDLE);
    busy       = (r_state != S_IDLE);
    frame_done = r_done;
    w_hs       = tx_valid && tx_ready;
    w_chkNext  = (CHK_MODE == 1) ? crc8Step(r_chk, tx_data) : r_chk + tx_data;
    rdreq_bus  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      rdreq_bus[i] = (r_state == S_DATA) && w_hs && (r_src == SW'(i));
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_next = S_PREFIX;
      S_PREFIX: if (w_hs) w_next = S_SOURCE;
      S_SOURCE: if (w_hs) w_next = S_LEN;
      S_LEN:    if (w_hs) w_next = (r_len != 8'd0) ? S_DATA : S_CHK;
      S_DATA:   if (w_hs && r_cnt == 8'd1) w_next = S_CHK;
      S_CHK:    if (w_hs) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= SW'(N_SRC - 1);
      r_src   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_chk   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_CHK) && w_hs;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_src  <= w_grant;
            r_len  <= w_lenArr[w_grant];
            r_chk  <= '0;
            r_last <= w_grant;
          end
        end
        S_SOURCE: if (w_hs) r_chk <= w_chkNext;
        S_LEN: begin
          if (w_hs) begin
            r_chk <= w_chkNext;
            r_cnt <= r_len;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            r_chk <= w_chkNext;
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cmd_framer.md
# cmd_framer

Parametrised packet framer that serialises messages from `N_SRC` show-ahead source FIFOs onto one byte stream. Each frame is: prefix, source ID, length, payload, check byte. Frame format is unchanged from the current encoder generation. This generation adds:
- fair round-robin arbitration that skips idle sources;
- a flat per-source bus with no input mapping table;
- zero-length payloads;
- a full-throughput valid/ready output;
- a selectable checksum (8-bit sum or CRC-8).

It sits between the per-interface message FIFOs and the UART/USB TX byte sink.

## Interface
- `N_SRC`, 8: number of sources, 1..256. The source ID field is always 8 bits.
- `PREFIX`, 8'hAA: frame start byte.
- `CHK_MODE`, 0: 0 = 8-bit modular sum; 1 = CRC-8, poly 0x07, init 0x00, MSB-first, no reflection, no final XOR.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `have_msg_bus`  in  N_SRC  bit i: source i has a complete message pending.
- `len_bus`  in  8*N_SRC  byte i: payload length of source i (0..255).
- `data_bus`  in  8*N_SRC  byte i: head byte of source i FIFO (show-ahead).
- `rdreq_bus`  out  N_SRC  one-hot pop strobe to source FIFOs.
- `tx_data`  out  8  output byte.
- `tx_valid`  out  1  tx_data valid.
- `tx_ready`  in  1  sink accepts byte when tx_valid & tx_ready (a "handshake").
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse after the check byte handshake.

## Operation
- States: IDLE, PREFIX, SOURCE, LEN, DATA, CHK. The state advances only on a handshake, except in IDLE.
- IDLE:
  - If any `have_msg_bus` bit is set, grant the first set index scanning circularly from `last_grant+1`.
  - On grant, latch `src`, latch `len = len_bus[src]`, clear `chk`, set `last_grant <= src`, go to PREFIX.
  - Without a request, stay in IDLE.
- `tx_data` is a combinational mux of the registered state: PREFIX → `PREFIX`; SOURCE → `src`; LEN → `len`; DATA → `data_bus[8*src+:8]`; CHK → `chk`; IDLE → 0.
- `tx_valid` = (state != IDLE).
- Handshake transitions:
  - PREFIX → SOURCE.
  - SOURCE → LEN.
  - LEN → DATA if len != 0, else CHK. Load byte counter `cnt = len`.
  - DATA: `cnt--`. Move to CHK when `cnt` reaches 0 on this handshake.
  - CHK → IDLE, and `frame_done` pulses the next cycle.
- `rdreq_bus` = (state==DATA & tx_valid & tx_ready) << src. It is combinational and pops exactly the byte just accepted. A new head byte must be visible the following cycle.
- `chk` update on each SOURCE, LEN and DATA handshake, using the byte accepted:
  - Sum mode: `chk + byte` mod 256.
  - CRC mode: one byte-wide CRC-8 step.
  - PREFIX is excluded from the check.
- Total frame length is len+4 bytes.
- `have_msg_bus`, `len_bus` and `data_bus` of non-granted sources are ignored during a frame.
- Dropping `have_msg_bus[src]` mid-frame is ignored; the frame completes.

## Timing
- Reset values:
  - outputs: `tx_valid`=0, `tx_data`=0, `rdreq_bus`=0, `busy`=0, `frame_done`=0;
  - internal: state IDLE, `last_grant`=N_SRC-1 (source 0 has first priority), `chk`=0, `cnt`=0.
- Request to first byte: a request seen in IDLE at edge k gives `tx_valid`=1 with PREFIX from cycle k+1.
- With `tx_ready` held high, one byte is sent per cycle and there is one IDLE cycle between frames.
- Backpressure: while `tx_valid` & !`tx_ready`, `tx_data`, state, `chk` and `cnt` hold, and `rdreq_bus`=0.
- Reset mid-frame: the next cycle is IDLE with `tx_valid`=0. The partial frame is abandoned with no check byte, no further pops and no `frame_done`. Arbitration restarts from source 0.
- Simultaneous requests: at most one grant per IDLE cycle. A source granted last goes to the end of the order.
- len=255: `cnt` is 8 bits, giving 255 pops and no wrap.

## Test plan
1. PREFIX=0xAA, sum mode, src 2, len 3, data 11/22/33, `tx_ready`=1 → stream AA 02 03 11 22 33 6B on consecutive cycles. `rdreq_bus`=0x04 on exactly 3 cycles. `frame_done` pulses once.
2. Same frame with `tx_ready` randomly toggled → identical byte sequence. `tx_data` is stable during stalls, and `rdreq_bus` pulses only on accepted data bytes.
3. Src 0, len 0 → AA 00 00 00, with no rdreq and `frame_done` asserted.
4. Sources 1 and 3 permanently pending, len 1 each → frames alternate src 1,3,1,3 (1 first after reset). Exactly one IDLE cycle separates frames.
5. CHK_MODE=1, src 1, len 1, data 00 → AA 01 01 00 7E.
6. Assert `rst` for one cycle during the second DATA byte of test 1 → `tx_valid`=0 the next cycle with no further rdreq. After release with src 0 pending, a complete correct frame from src 0 follows.
